spin_energy_unit: RTL

Multi-cycle, handshaked successor to the single-beat column compute unit in the Ising energy datapath. It latches one spin-update descriptor (flip mask, keep mask, new spins) and consumes the full J matrix as a stream of COL_PER_CC-column beats. It computes the flipped/unflipped cross-term energy ΔE = Σ_k w_k · Σ_i J[i][k] · s_i and returns it on a valid/ready result port. It sits between the J-matrix memory streamer and the annealing controller.

---
 rtl/spin_energy_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spin_energy_unit.sv
// spin_energy_unit: streamed Ising cross-term energy dE = sum_k w_k * sum_i J[i][k] * s_i.
// SPIN_ENERGY_SAT_EN selects a saturating accumulator with sticky overflow; default wraps.
module spin_energy_unit #(
  parameter int VECTOR_SIZE   = 256,
  parameter int DATA_WIDTH    = 4,
  parameter int COL_PER_CC    = 1,
  parameter int REDUCE_STAGES = 2,
  parameter int ACCUM_WIDTH   = DATA_WIDTH + $clog2(VECTOR_SIZE * VECTOR_SIZE) + 1
) (
  input  logic                                                       clk,
  input  logic                                                       rst_n,
  input  logic                                                       start_i,
  input  logic [VECTOR_SIZE-1:0]                                     sigma_f_i,
  input  logic [VECTOR_SIZE-1:0]                                     sigma_f_inv_i,
  input  logic [VECTOR_SIZE-1:0]                                     sigma_new_i,
  output logic                                                       busy_o,
  input  logic signed [COL_PER_CC-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] j_cols_i,
  input  logic                                                       j_valid_i,
  output logic                                                       j_ready_o,
  input  logic                                                       clear_i,
  output logic signed [ACCUM_WIDTH-1:0]                              result_o,
  output logic                                                       result_valid_o,
  input  logic                                                       result_ready_i,
  output logic                                                       overflow_o
);
  localparam int NUM_BEATS = VECTOR_SIZE / COL_PER_CC;
  localparam int L = $clog2(VECTOR_SIZE);
  localparam int P = 1 << L;
  localparam int CW = DATA_WIDTH + 1 + L;
  localparam int BW = CW + $clog2(COL_PER_CC) + 1;
  localparam int SW = (BW > ACCUM_WIDTH ? BW : ACCUM_WIDTH) + 1;
  localparam int CNTW = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
  localparam int DCW = $clog2(REDUCE_STAGES + 1) + 1;
  localparam int PW = 2 * COL_PER_CC + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [VECTOR_SIZE-1:0] f_q, inv_q, new_q;
  logic [CNTW-1:0] cnt_q;
  logic [DCW-1:0] dcnt_q;
  logic signed [ACCUM_WIDTH-1:0] acc_q, acc_d;
  logic signed [CW-1:0] node [COL_PER_CC][L+1][P];
  logic signed [CW-1:0] node_q [COL_PER_CC][L+1][P];
  logic signed [DATA_WIDTH:0] t;
  logic signed [BW-1:0] dx, beat;
  logic signed [SW-1:0] ax, bx, sum;
  logic [PW-1:0] pin, pout;
  logic accept, last;
`ifdef SPIN_ENERGY_SAT_EN
  logic clamp, ovf_q;
`endif
  assign accept = j_valid_i && state_q == RUN;
  assign last = cnt_q == CNTW'(NUM_BEATS - 1);
  // sideband per beat: {column nonzero weights, column negative weights, valid}
  assign pin = {COL_PER_CC'(f_q >> (int'(cnt_q) * COL_PER_CC)),
                ~COL_PER_CC'(new_q >> (int'(cnt_q) * COL_PER_CC)),
                accept && !clear_i};
  assign busy_o = state_q != IDLE;
  assign j_ready_o = state_q == RUN;
  assign result_valid_o = state_q == DONE;
  assign result_o = acc_q;
  // row-reduction tree; the last REDUCE_STAGES levels are registered
  always_comb begin
    t = '0;
    for (int c = 0; c < COL_PER_CC; c++) begin
      for (int i = 0; i < P; i++) node[c][0][i] = '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        t = $signed(j_cols_i[c][i]);
        if (!new_q[i]) t = -t;
        if (!inv_q[i]) t = '0;
        node[c][0][i] = t;
      end
      for (int l = 1; l <= L; l++) begin
        for (int j = 0; j < P; j++) node[c][l][j] = '0;
        for (int j = 0; j < P / 2; j++)
          node[c][l][j] = (l - 1 > L - REDUCE_STAGES)
            ? node_q[c][l-1][2*j] + node_q[c][l-1][2*j+1]
            : node[c][l-1][2*j] + node[c][l-1][2*j+1];
      end
    end
  end
  always_ff @(posedge clk) node_q <= node;
  if (REDUCE_STAGES == 0) begin : g_nopipe
    assign pout = pin;
  end else begin : g_pipe
    logic [PW-1:0] sr [REDUCE_STAGES];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < REDUCE_STAGES; s++) sr[s] <= '0;
      end else begin
        sr[0] <= pin;
        for (int s = 1; s < REDUCE_STAGES; s++) sr[s] <= {sr[s-1][PW-1:1], sr[s-1][0] & ~clear_i};
      end
    end
    assign pout = sr[REDUCE_STAGES-1];
  end
  always_comb begin
    beat = '0;
    dx = '0;
    for (int c = 0; c < COL_PER_CC; c++) begin
      dx = REDUCE_STAGES > 0 ? node_q[c][L][0] : node[c][L][0];
      if (pout[1 + c]) dx = -dx;
      if (!pout[1 + COL_PER_CC + c]) dx = '0;
      beat = beat + dx;
    end
    ax = acc_q;
    bx = beat;
    sum = ax + bx;
`ifdef SPIN_ENERGY_SAT_EN
    clamp = sum[SW-1:ACCUM_WIDTH-1] != '0 && sum[SW-1:ACCUM_WIDTH-1] != '1;
    acc_d = clamp ? {sum[SW-1], {(ACCUM_WIDTH-1){~sum[SW-1]}}} : ACCUM_WIDTH'(sum);
`else
    acc_d = ACCUM_WIDTH'(sum);
`endif
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (accept && last) state_d = DRAIN;
      DRAIN:   if (dcnt_q == DCW'(REDUCE_STAGES)) state_d = DONE;
      DONE:    if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f_q <= '0;
      inv_q <= '0;
      new_q <= '0;
      cnt_q <= '0;
      dcnt_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q <= state_q == DRAIN ? dcnt_q + 1'b1 : '0;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (state_q == IDLE && start_i) begin
        f_q <= sigma_f_i;
        inv_q <= sigma_f_inv_i;
        new_q <= sigma_new_i;
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        if (accept) cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (pout[0]) acc_q <= acc_d;
      end
    end
  end
`ifdef SPIN_ENERGY_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (clear_i || (state_q == IDLE && start_i)) ovf_q <= 1'b0;
    else if (pout[0] && clamp) ovf_q <= 1'b1;
  end
  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif
endmodule
